// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: field split, immediate generation, one-hot format; DECODE_ILLEGAL_EN adds out_illegal.
// Latency 1 cycle. A 2-entry skid buffer means in_ready comes only from a register.
// When out is held, one more word is captured in the skid entry and in_ready drops the next cycle.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16,
   localparam int SHW  = (XLEN == 64) ? 6 : 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [6:0]       out_opcode,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [6:0]       out_funct7,
   output logic [SHW-1:0]   out_shamt,
   output logic [XLEN-1:0]  out_imm,
   output logic [5:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] dec_count
);

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OPIM32 = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [5:0] FMT_R = 6'b000001;
   localparam logic [5:0] FMT_I = 6'b000010;
   localparam logic [5:0] FMT_S = 6'b000100;
   localparam logic [5:0] FMT_B = 6'b001000;
   localparam logic [5:0] FMT_U = 6'b010000;
   localparam logic [5:0] FMT_J = 6'b100000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [SHW-1:0]  shamt;
      logic [XLEN-1:0] imm;
      logic [5:0]      fmt;
   } dec_t;

   dec_t        dec_d;
   dec_t        out_q;
   dec_t        skid_q;
   logic        out_vld;
   logic        skid_vld;
   logic [31:0] imm32;
   logic [6:0]  op;

   assign op = in_instr[6:0];

   // Immediates are built at 32 bits and then sign-extended, so one path serves both XLENs.
   always_comb begin
      dec_d        = '0;
      imm32        = '0;
      dec_d.pc     = in_pc;
      dec_d.opcode = op;
      dec_d.rd     = in_instr[11:7];
      dec_d.rs1    = in_instr[19:15];
      dec_d.rs2    = in_instr[24:20];
      dec_d.funct3 = in_instr[14:12];
      dec_d.funct7 = in_instr[31:25];
      case (op)
         OP_OP, OP_OP32: dec_d.fmt = FMT_R;
         OP_OPIMM, OP_LOAD, OP_JALR, OP_OPIM32: begin
            dec_d.fmt = FMT_I;
            dec_d.rs2 = '0;
            imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            if ((op == OP_OPIMM || op == OP_OPIM32) && in_instr[13:12] == 2'b01)
               dec_d.shamt = in_instr[20 +: SHW];
            else
               dec_d.funct7 = '0;
         end
         OP_STORE: begin
            dec_d.fmt    = FMT_S;
            dec_d.rd     = '0;
            dec_d.funct7 = '0;
            imm32        = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BRANCH: begin
            dec_d.fmt    = FMT_B;
            dec_d.rd     = '0;
            dec_d.funct7 = '0;
            imm32        = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC, OP_JAL: begin
            dec_d.fmt    = (op == OP_JAL) ? FMT_J : FMT_U;
            dec_d.rs1    = '0;
            dec_d.rs2    = '0;
            dec_d.funct3 = '0;
            dec_d.funct7 = '0;
            if (op == OP_JAL)
               imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            else
               imm32 = {in_instr[31:12], 12'b0};
         end
         default: ;
      endcase
      dec_d.imm = XLEN'($signed(imm32));
   end

   logic in_fire;
   logic out_fire;
   logic out_free;
   logic ld_skid2out;
   logic ld_in2out;
   logic ld_in2skid;

   assign in_ready    = !skid_vld;
   assign in_fire     = in_valid && !skid_vld;
   assign out_fire    = out_vld && out_ready;
   assign out_free    = !out_vld || out_ready;
   assign ld_skid2out = !flush && out_free && skid_vld;
   assign ld_in2out   = !flush && out_free && !skid_vld && in_fire;
   assign ld_in2skid  = !flush && !out_free && in_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else begin
         if (out_free)
            out_vld <= skid_vld || in_fire;
         if (ld_skid2out) begin
            out_q    <= skid_q;
            skid_vld <= 1'b0;
         end else if (ld_in2out) begin
            out_q <= dec_d;
         end
         if (ld_in2skid) begin
            skid_q   <= dec_d;
            skid_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dec_count <= '0;
      else if (out_fire && dec_count != {CNT_W{1'b1}})
         dec_count <= dec_count + CNT_W'(1);
   end

`ifdef DECODE_ILLEGAL_EN
   logic ill_d;
   logic ill_out;
   logic ill_skid;

   // RV64-only word opcodes are rejected when built for RV32.
   assign ill_d = (in_instr[1:0] != 2'b11) || (dec_d.fmt == 6'b0) ||
                  ((XLEN == 32) && (op == OP_OP32 || op == OP_OPIM32));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_out  <= 1'b0;
         ill_skid <= 1'b0;
      end else begin
         if (ld_skid2out)
            ill_out <= ill_skid;
         else if (ld_in2out)
            ill_out <= ill_d;
         if (ld_in2skid)
            ill_skid <= ill_d;
      end
   end

   assign out_illegal = ill_out;
`else
   assign out_illegal = 1'b0;
`endif

   assign out_valid  = out_vld;
   assign out_pc     = out_q.pc;
   assign out_opcode = out_q.opcode;
   assign out_rd     = out_q.rd;
   assign out_rs1    = out_q.rs1;
   assign out_rs2    = out_q.rs2;
   assign out_funct3 = out_q.funct3;
   assign out_funct7 = out_q.funct7;
   assign out_shamt  = out_q.shamt;
   assign out_imm    = out_q.imm;
   assign out_fmt    = out_q.fmt;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I decode stage between fetch and register read in the pipelined core.
- Accepts raw instruction words and their PC over a valid/ready handshake.
- Splits each word into type-qualified fields (unused fields zeroed) and generates the sign-extended immediate plus a one-hot format.
- Holds results in a 2-entry skid buffer so back-pressure never forms a combinational ready path; supports pipeline flush and a decoded-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets PC/immediate width and shamt width (SHW = 5 when XLEN=32, 6 when XLEN=64).
- CNT_W, 16, width of the saturating decoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  passed-through PC
- out_opcode  out  7  instr[6:0]
- out_rd / out_rs1 / out_rs2  out  5 each  register indices, zeroed when unused
- out_funct3  out  3  zeroed when unused
- out_funct7  out  7  zeroed when unused
- out_shamt  out  SHW  shift amount; 0 when not an OP-IMM shift
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type
- out_fmt  out  6  one-hot {J,U,B,S,I,R}; all-zero for unknown opcodes
- out_illegal  out  1  illegal instruction flag (see Optional Feature)
- dec_count  out  CNT_W  saturating count of output handshakes

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, skid entry invalid, in_ready=1, dec_count=0.
  - All data outputs are 0.
- Latency: a word accepted at edge N appears on the outputs after edge N (1 cycle), provided the output register is empty or draining.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - in_ready is registered: in_ready = !skid_valid.
  - Output data is stable while out_valid && !out_ready.
- Skid buffer:
  - Accept while the output is empty or draining: load the output register.
  - Accept while the output is held (out_valid && !out_ready): load the skid register, which drops in_ready next cycle.
  - On the next out handshake, skid moves to output and in_ready rises.
  - Order is preserved; no word is duplicated or lost.
- Flush:
  - Highest priority; clears out_valid and skid_valid at the edge.
  - An input presented in the flush cycle is dropped.
  - in_ready=1 on the following cycle.
  - dec_count is unaffected.
- Field decode (opcode -> format, zeroing):
  - R, 0110011 / 0111011: all fields kept.
  - I, 0010011 / 0000011 / 1100111 / 0011011:
    - rs2=0.
    - funct7 kept only for OP-IMM shifts (funct3 001/101); otherwise 0.
    - shamt = instr[20+SHW-1:20] for shifts.
  - S, 0100011, and B, 1100011: rd=0, funct7=0.
  - U, 0110111 / 0010111: rs1=rs2=funct3=funct7=0.
  - J, 1101111: rs1=rs2=funct3=funct7=0.
  - Unknown opcode: fields passed raw, out_fmt=0, out_imm=0.
- Immediates, sign bit instr[31] replicated to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- dec_count increments on each out handshake and holds at all-ones.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined: out_illegal=1 for a decoded word when any of these hold:
  - instr[1:0] != 2'b11;
  - opcode is unknown;
  - opcode is 0111011 or 0011011 with XLEN=32.
  - out_illegal is registered with the other fields and reset to 0.
- Undefined: out_illegal is tied 0; no logic is generated.

Test Plan:
- Reset, XLEN=32: hold rst_n=0 for 3 cycles, then release -> out_valid=0, in_ready=1, dec_count=0, all outputs 0.
- Single decode: in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_fmt=I, rd=1, rs2=0, funct7=0, imm=0xFFFFFFFF.
- Back-pressure: out_ready=0 while 0x00208663 (beq) then 0x00C0006F (jal) are sent -> in_ready falls after the second accept. Then raise out_ready:
  - beq emerges first: rd=0, imm=0xC.
  - jal emerges next: rs1=0, imm=0xC.
  - in_ready rises again.
- Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped word never appears.
- XLEN=64 shift: in_instr=0x03F09093 (slli x1,x1,63) -> shamt=63, funct7=0x01.
- With DECODE_ILLEGAL_EN defined: in_instr=0x00000000 -> out_illegal=1. After 2^CNT_W handshakes, dec_count holds at all-ones.
